// File: rtl/pia_port_if.sv
// pia_port_if: register-bus bundle between 6520 decode logic (master) and pia_port_ctrl (slave); cs/we/addr/wdata in, registered rdata out
interface pia_port_if #(parameter int WIDTH = 8);
  logic             cs;
  logic             we;
  logic [1:0]       addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  modport master (output cs, we, addr, wdata, input rdata);
  modport slave (input cs, we, addr, wdata, output rdata);
endinterface

// File: rtl/pia_port_ctrl.sv
// pia_port_ctrl: 6520-style port (OR/DDR/CTRL/flag) with synchronised pins, CL1 edge irq and CL2 handshake/pulse; ports clk, rst, bus (slave), perifbus_io, cl1_i, cl2_o, irq_o
module pia_port_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  pia_port_if.slave        bus,
  inout  wire  [WIDTH-1:0] perifbus_io,
  input  logic             cl1_i,
  output logic             cl2_o,
  output logic             irq_o
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PULSE} state_t;
  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       or_q, or_d, ddr_q, ddr_d, rdata_q, rdata_d;
  logic [3:0]             ctrl_q, ctrl_d;
  logic                   flag_q, flag_d, cl1_prev_q;
  logic [WIDTH-1:0]       pin_sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] cl1_sync_q;
  logic                   wr, rd, wr_or, rd_or, wr_ctrl, mode_chg, cl1_s, active;
  logic [WIDTH-1:0]       sync_pin, port_val;
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign perifbus_io[i] = ddr_q[i] ? or_q[i] : 1'bz;
  end
  assign sync_pin = pin_sync_q[SYNC_STAGES-1];
  assign cl1_s    = cl1_sync_q[SYNC_STAGES-1];
  always_comb begin
    wr       = bus.cs & bus.we;
    rd       = bus.cs & ~bus.we;
    wr_or    = wr && bus.addr == 2'd0;
    rd_or    = rd && bus.addr == 2'd0;
    wr_ctrl  = wr && bus.addr == 2'd2;
    mode_chg = wr_ctrl && bus.wdata[3:2] != ctrl_q[3:2];
    // edge = synchronised level differs from last cycle's, in the direction CTRL[1] selects
    active   = ctrl_q[1] ? (cl1_s & ~cl1_prev_q) : (~cl1_s & cl1_prev_q);
    port_val = (ddr_q & or_q) | (~ddr_q & sync_pin);
    or_d     = wr_or ? bus.wdata : or_q;
    ddr_d    = (wr && bus.addr == 2'd1) ? bus.wdata : ddr_q;
    ctrl_d   = wr_ctrl ? bus.wdata[3:0] : ctrl_q;
    // set beats the clearing read when both land on the same edge
    flag_d   = active | (flag_q & ~rd_or);
    rdata_d  = !rd              ? rdata_q :
               bus.addr == 2'd0 ? port_val :
               bus.addr == 2'd1 ? ddr_q :
               bus.addr == 2'd2 ? WIDTH'(ctrl_q) : WIDTH'(flag_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      or_q       <= '0;
      ddr_q      <= '0;
      ctrl_q     <= '0;
      flag_q     <= 1'b0;
      rdata_q    <= '0;
      cl1_sync_q <= '0;
      cl1_prev_q <= 1'b0;
      for (int k = 0; k < SYNC_STAGES; k++) pin_sync_q[k] <= '0;
    end else begin
      or_q       <= or_d;
      ddr_q      <= ddr_d;
      ctrl_q     <= ctrl_d;
      flag_q     <= flag_d;
      rdata_q    <= rdata_d;
      cl1_sync_q <= {cl1_sync_q[SYNC_STAGES-2:0], cl1_i};
      cl1_prev_q <= cl1_s;
      pin_sync_q[0] <= perifbus_io;
      for (int k = 1; k < SYNC_STAGES; k++) pin_sync_q[k] <= pin_sync_q[k-1];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end
  // static modes and any mode change park the FSM in IDLE; mode 11 re-arms on every OR write
  always_comb begin
    state_d = (mode_chg || !ctrl_q[3]) ? S_IDLE :
              ctrl_q[2]                ? (wr_or ? S_PULSE : S_IDLE) :
              state_q == S_WAIT        ? (active ? S_IDLE : S_WAIT) :
                                         (rd_or ? S_WAIT : S_IDLE);
  end
  always_comb begin
    cl2_o     = ctrl_q[3] ? (state_q == S_IDLE) : ~ctrl_q[2];
    irq_o     = flag_q & ctrl_q[0];
    bus.rdata = rdata_q;
  end
endmodule

// File: tb/tb_pia_port_ctrl.sv
// tb_pia_port_ctrl: directed self-checking bench for pia_port_ctrl
module tb_pia_port_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cl1 = 1'b0;
  logic       cl2, irq;
  logic [7:0] tb_oe = '0;
  logic [7:0] tb_val = '0;
  wire  [7:0] pins;
  int         checks = 0;
  int         failures = 0;
  pia_port_if #(.WIDTH(8)) bus ();
  for (genvar g = 0; g < 8; g++) begin : g_drv
    assign pins[g] = tb_oe[g] ? tb_val[g] : 1'bz;
  end
  pia_port_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .perifbus_io(pins),
    .cl1_i(cl1), .cl2_o(cl2), .irq_o(irq)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    tick();
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask
  task automatic rd(input logic [1:0] a);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
    tick();
    bus.cs = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (bus.rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", bus.rdata); end
    checks++; if (cl2 !== 1'b1) begin failures++; $display("FAIL reset_cl2 got=%b exp=1", cl2); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    tb_oe = 8'hFF; tb_val = 8'hA5;
    tick(); tick();
    rd(2'd0);
    checks++; if (bus.rdata !== 8'hA5) begin failures++; $display("FAIL input_read got=%h exp=a5", bus.rdata); end
    checks++; if (pins !== 8'hA5) begin failures++; $display("FAIL input_pins got=%h exp=a5", pins); end
  endtask
  task automatic test_mixed_dir();
    tb_oe = 8'h0F; tb_val = 8'h09;
    wr(2'd1, 8'hF0);
    wr(2'd0, 8'h3C);
    checks++; if (pins !== 8'h39) begin failures++; $display("FAIL mixed_pins got=%h exp=39", pins); end
    tick(); tick(); tick();
    rd(2'd0);
    checks++; if (bus.rdata !== 8'h39) begin failures++; $display("FAIL mixed_read got=%h exp=39", bus.rdata); end
    rd(2'd1);
    checks++; if (bus.rdata !== 8'hF0) begin failures++; $display("FAIL ddr_read got=%h exp=f0", bus.rdata); end
    tick();
    checks++; if (bus.rdata !== 8'hF0) begin failures++; $display("FAIL rdata_hold got=%h exp=f0", bus.rdata); end
  endtask
  task automatic test_cl1_irq();
    wr(2'd2, 8'hF3);
    rd(2'd2);
    checks++; if (bus.rdata !== 8'h03) begin failures++; $display("FAIL ctrl_read got=%h exp=03", bus.rdata); end
    cl1 = 1'b1;
    tick();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_edge1 got=%b exp=0", irq); end
    tick();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_edge2 got=%b exp=0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_edge3 got=%b exp=1", irq); end
    rd(2'd3);
    checks++; if (bus.rdata !== 8'h01) begin failures++; $display("FAIL flag_read got=%h exp=01", bus.rdata); end
    rd(2'd0);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", irq); end
    cl1 = 1'b0;
    tick(); tick(); tick(); tick();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL falling_noset got=%b exp=0", irq); end
    rd(2'd3);
    checks++; if (bus.rdata !== 8'h00) begin failures++; $display("FAIL falling_flag got=%h exp=00", bus.rdata); end
  endtask
  task automatic test_handshake();
    wr(2'd2, 8'h0B);
    checks++; if (cl2 !== 1'b1) begin failures++; $display("FAIL hs_idle got=%b exp=1", cl2); end
    rd(2'd0);
    checks++; if (cl2 !== 1'b0) begin failures++; $display("FAIL hs_wait got=%b exp=0", cl2); end
    tick(); tick(); tick();
    checks++; if (cl2 !== 1'b0) begin failures++; $display("FAIL hs_hold got=%b exp=0", cl2); end
    cl1 = 1'b1;
    tick(); tick();
    checks++; if (cl2 !== 1'b0) begin failures++; $display("FAIL hs_pre got=%b exp=0", cl2); end
    tick();
    checks++; if (cl2 !== 1'b1) begin failures++; $display("FAIL hs_release got=%b exp=1", cl2); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL hs_irq got=%b exp=1", irq); end
    rd(2'd0);
    checks++; if (cl2 !== 1'b0) begin failures++; $display("FAIL hs_rearm got=%b exp=0", cl2); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL hs_irq_clear got=%b exp=0", irq); end
    cl1 = 1'b0;
    tick(); tick(); tick(); tick();
    checks++; if (cl2 !== 1'b0) begin failures++; $display("FAIL hs_fall_hold got=%b exp=0", cl2); end
  endtask
  task automatic test_pulse();
    wr(2'd2, 8'h0C);
    checks++; if (cl2 !== 1'b1) begin failures++; $display("FAIL pulse_idle got=%b exp=1", cl2); end
    wr(2'd0, 8'h55);
    checks++; if (cl2 !== 1'b0) begin failures++; $display("FAIL pulse_low got=%b exp=0", cl2); end
    checks++; if (pins[7:4] !== 4'h5) begin failures++; $display("FAIL pulse_pins got=%h exp=5", pins[7:4]); end
    tick();
    checks++; if (cl2 !== 1'b1) begin failures++; $display("FAIL pulse_end got=%b exp=1", cl2); end
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 2'd0; bus.wdata = 8'hAA;
    tick();
    checks++; if (cl2 !== 1'b0) begin failures++; $display("FAIL b2b_first got=%b exp=0", cl2); end
    tick();
    bus.cs = 1'b0; bus.we = 1'b0;
    checks++; if (cl2 !== 1'b0) begin failures++; $display("FAIL b2b_second got=%b exp=0", cl2); end
    tick();
    checks++; if (cl2 !== 1'b1) begin failures++; $display("FAIL b2b_end got=%b exp=1", cl2); end
    wr(2'd2, 8'h04);
    checks++; if (cl2 !== 1'b0) begin failures++; $display("FAIL static_low got=%b exp=0", cl2); end
  endtask
  task automatic test_set_wins_and_reset();
    wr(2'd2, 8'h0B);
    rd(2'd0);
    checks++; if (cl2 !== 1'b0) begin failures++; $display("FAIL sw_wait got=%b exp=0", cl2); end
    cl1 = 1'b1;
    tick(); tick();
    rd(2'd0);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL set_wins_irq got=%b exp=1", irq); end
    checks++; if (cl2 !== 1'b1) begin failures++; $display("FAIL set_wins_cl2 got=%b exp=1", cl2); end
    rd(2'd3);
    checks++; if (bus.rdata !== 8'h01) begin failures++; $display("FAIL set_wins_flag got=%h exp=01", bus.rdata); end
    rd(2'd0);
    checks++; if (cl2 !== 1'b0) begin failures++; $display("FAIL rst_pre_wait got=%b exp=0", cl2); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (cl2 !== 1'b1) begin failures++; $display("FAIL rst_cl2 got=%b exp=1", cl2); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", irq); end
    checks++; if (bus.rdata !== 8'h00) begin failures++; $display("FAIL rst_rdata got=%h exp=00", bus.rdata); end
    rd(2'd1);
    checks++; if (bus.rdata !== 8'h00) begin failures++; $display("FAIL rst_ddr got=%h exp=00", bus.rdata); end
    rd(2'd2);
    checks++; if (bus.rdata !== 8'h00) begin failures++; $display("FAIL rst_ctrl got=%h exp=00", bus.rdata); end
    tb_oe = 8'hFF; tb_val = 8'hC3;
    tick(); tick();
    rd(2'd0);
    checks++; if (bus.rdata !== 8'hC3) begin failures++; $display("FAIL rst_hiz_read got=%h exp=c3", bus.rdata); end
    checks++; if (pins !== 8'hC3) begin failures++; $display("FAIL rst_hiz_pins got=%h exp=c3", pins); end
  endtask
  initial begin
    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 8'h00;
    test_reset();
    test_mixed_dir();
    test_cl1_irq();
    test_handshake();
    test_pulse();
    test_set_wins_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
